// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_frame #(
  parameter int unsigned CLK_FREQUENCE = 50_000_000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned PARITY_ODD    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int unsigned BAUD_CNT = CLK_FREQUENCE / BAUD_RATE;
  localparam int unsigned CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam int unsigned IDX_W    = $clog2(DATA_BITS + 1);

  // Reject configurations the frame logic cannot represent.
  if (BAUD_CNT < 2) begin : g_bad_baud
    $error("uart_tx_frame: BAUD_CNT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_baud_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
`ifdef UART_TX_PARITY_EN
  logic                 r_par;
`endif
  logic                 w_bit_end;

  assign w_bit_end = (r_baud_cnt == CNT_W'(BAUD_CNT - 1));

  // Outputs are registered one cycle behind the state, so the line follows the FSM by a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_busy     <= (r_state != S_IDLE);
      r_done     <= (r_state == S_IDLE) && r_busy;
      r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          r_tx       <= 1'b1;
          r_baud_cnt <= '0;
          if (tx_start) begin
            r_shift   <= tx_data;
            r_bit_idx <= '0;
            r_state   <= S_START;
`ifdef UART_TX_PARITY_EN
            r_par     <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
          end
        end
        S_START: begin
          r_tx <= 1'b0;
          if (w_bit_end) begin
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          r_tx <= r_shift[0];
          if (w_bit_end) begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_state   <= S_PARITY;
`else
              r_state   <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          r_tx <= r_par;
          if (w_bit_end) begin
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          r_tx <= 1'b1;
          // Bit index doubles as the stop-bit counter.
          if (w_bit_end) begin
            if (r_bit_idx == IDX_W'(STOP_BITS - 1)) begin
              r_bit_idx <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule
